// File: rtl/rtl_stream_pkg.sv
// Shared definitions for the SIMD adder stream: word width, transaction length,
// derived sum width and the reader FSM encoding.
package rtl_stream_pkg;

  localparam int STREAM_W       = 11;
  localparam int STREAM_N_WORDS = 4;

  function automatic int sum_width(input int w, input int n_words);
    return w + $clog2(n_words);
  endfunction

  localparam int STREAM_SW = sum_width(STREAM_W, STREAM_N_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } stream_state_t;

endpackage

// File: rtl/rtl_stream_accum.sv
// Sum/peak datapath for one stream transaction; exposes the updated values so the
// caller can register a result that already includes the word being accepted.
module rtl_stream_accum #(
  parameter int W  = 11,
  parameter int SW = 13
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          en,
  input  logic          clear,
  input  logic          accept,
  input  logic [W-1:0]  din,
  output logic [SW-1:0] sum_nxt,
  output logic [W-1:0]  max_nxt
);

  logic [SW-1:0] acc;
  logic [W-1:0]  max_q;

  assign sum_nxt = acc + {{(SW-W){1'b0}}, din};
  assign max_nxt = (din > max_q) ? din : max_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc   <= '0;
      max_q <= '0;
    end else if (en) begin
      if (clear) begin
        acc   <= '0;
        max_q <= '0;
      end else if (accept) begin
        acc   <= sum_nxt;
        max_q <= max_nxt;
      end
    end
  end

endmodule

// File: rtl/rtl_simple_algo_stream_reader.sv
// Drains N_WORDS words from an ap_fifo stream under ap_ctrl_chain and returns
// their sum and maximum.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   IDLE    | waiting for ap_start; ap_idle high
//   READ    | popping words while the FIFO is non-empty
//   DONE    | results valid on ap_return_*; waiting for ap_continue
module rtl_simple_algo_stream_reader
  import rtl_stream_pkg::*;
#(
  parameter int W       = STREAM_W,
  parameter int N_WORDS = STREAM_N_WORDS,
  parameter int SW      = W + $clog2(N_WORDS)
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          ap_ce,
  input  logic          ap_start,
  input  logic          ap_continue,
  output logic          ap_done,
  output logic          ap_idle,
  output logic          ap_ready,
  input  logic [W-1:0]  z_dout,
  input  logic          z_empty_n,
  output logic          z_read,
  output logic [SW-1:0] ap_return_sum,
  output logic [W-1:0]  ap_return_max
);

  localparam int CW = $clog2(N_WORDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_WORDS - 1);

  stream_state_t state;
  logic [CW-1:0] cnt;
  logic          last_word;
  logic          acc_clear;
  logic [SW-1:0] sum_nxt;
  logic [W-1:0]  max_nxt;

  assign z_read    = (state == ST_READ) && z_empty_n && ap_ce;
  assign last_word = z_read && (cnt == CNT_LAST);
  assign ap_ready  = last_word;
  assign ap_idle   = (state == ST_IDLE);
  assign ap_done   = (state == ST_DONE);

  // Both entries into READ start from a clean accumulator.
  assign acc_clear = ap_start && ((state == ST_IDLE) || ((state == ST_DONE) && ap_continue));

  rtl_stream_accum #(
    .W  (W),
    .SW (SW)
  ) u_accum (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .en       (ap_ce),
    .clear    (acc_clear),
    .accept   (z_read),
    .din      (z_dout),
    .sum_nxt  (sum_nxt),
    .max_nxt  (max_nxt)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      ap_return_sum <= '0;
      ap_return_max <= '0;
    end else if (ap_ce) begin
      case (state)
        ST_IDLE: begin
          if (ap_start) begin
            state <= ST_READ;
            cnt   <= '0;
          end
        end
        ST_READ: begin
          if (z_read) begin
            if (cnt == CNT_LAST) begin
              cnt           <= '0;
              ap_return_sum <= sum_nxt;
              ap_return_max <= max_nxt;
              state         <= ST_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (ap_continue) begin
            state <= ap_start ? ST_READ : ST_IDLE;
            cnt   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtl_simple_algo_stream_reader.sv
// Bench for the stream reader: a queue-based FIFO model feeds words, and sum/max
// expectations come from plain loops over the words pushed.
module tb_rtl_simple_algo_stream_reader;

  localparam int W  = 11;
  localparam int N  = 4;
  localparam int SW = 13;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n, ap_ce, ap_start, ap_continue;
  logic          ap_done, ap_idle, ap_ready;
  logic [W-1:0]  z_dout;
  logic          z_empty_n, z_read;
  logic [SW-1:0] ap_return_sum;
  logic [W-1:0]  ap_return_max;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fifo[$];
  logic [W-1:0] exp_q[$];
  int   gap_cfg = 0;
  int   gap_left = 0;
  logic rd_q = 1'b0;
  int   pause_after = -1;
  int   pause_len = 0;

  // results of the last run_txn
  int            r_done, r_ready, r_nreads, r_ready_cnt, r_bad, r_idle_seen;
  logic [SW-1:0] r_sum;
  logic [W-1:0]  r_max;

  always #5 ap_clk = ~ap_clk;

  rtl_simple_algo_stream_reader dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .ap_ce         (ap_ce),
    .ap_start      (ap_start),
    .ap_continue   (ap_continue),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .z_dout        (z_dout),
    .z_empty_n     (z_empty_n),
    .z_read        (z_read),
    .ap_return_sum (ap_return_sum),
    .ap_return_max (ap_return_max)
  );

  function automatic int model_sum(input logic [W-1:0] q[$]);
    int s = 0;
    foreach (q[i]) s += int'(q[i]);
    return s;
  endfunction

  function automatic int model_max(input logic [W-1:0] q[$]);
    int m = 0;
    foreach (q[i]) if (int'(q[i]) > m) m = int'(q[i]);
    return m;
  endfunction

  task automatic update_pins();
    z_empty_n = (fifo.size() > 0) && (gap_left == 0);
    z_dout    = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  // One clock: note the pop decision before the edge, apply it at the edge,
  // return at the following negedge with refreshed FIFO pins.
  task automatic tick();
    #1 rd_q = z_read;
    @(posedge ap_clk);
    if (rd_q) begin
      fifo.delete(0);
      gap_left = gap_cfg;
    end else if (gap_left > 0) begin
      gap_left--;
    end
    @(negedge ap_clk);
    update_pins();
  endtask

  task automatic push_random();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(W'($urandom_range(0, 2047)));
    foreach (exp_q[i]) fifo.push_back(exp_q[i]);
    update_pins();
  endtask

  task automatic push_words(input int a, input int b, input int c, input int d);
    exp_q.delete();
    exp_q.push_back(W'(a)); exp_q.push_back(W'(b));
    exp_q.push_back(W'(c)); exp_q.push_back(W'(d));
    foreach (exp_q[i]) fifo.push_back(exp_q[i]);
    update_pins();
  endtask

  // Cycle 0: ap_start (and ap_continue) high for one edge; returns z_read seen then.
  task automatic launch(input logic cont, output logic zr0);
    gap_left = 0;
    update_pins();
    ap_start    = 1'b1;
    ap_continue = cont;
    #1 zr0 = z_read;
    tick();
    ap_start    = 1'b0;
    ap_continue = 1'b0;
  endtask

  // Runs cycles 1.. until ap_done is seen, recording handshake activity.
  task automatic run_txn();
    int pause_left = pause_len;
    logic got = 1'b0;
    r_done = -1; r_ready = -1; r_nreads = 0; r_ready_cnt = 0; r_bad = 0; r_idle_seen = 0;
    r_sum = '0; r_max = '0;
    for (int cyc = 1; cyc <= 200 && !got; cyc++) begin
      if (pause_after >= 0 && r_nreads == pause_after && pause_left > 0) begin
        ap_ce = 1'b0;
        pause_left--;
      end else begin
        ap_ce = 1'b1;
      end
      #1;
      if (z_read && !z_empty_n) r_bad++;
      if (!ap_ce && (z_read || ap_ready)) r_bad++;
      if (ap_idle) r_idle_seen++;
      if (z_read) r_nreads++;
      if (ap_ready) begin r_ready_cnt++; r_ready = cyc; end
      if (ap_done) begin
        r_done = cyc; r_sum = ap_return_sum; r_max = ap_return_max; got = 1'b1;
      end else begin
        tick();
      end
    end
    ap_ce = 1'b1;
  endtask

  task automatic release_done();
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; ap_ce = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
    update_pins();
    repeat (2) @(negedge ap_clk);
    #1;
    checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
    checks++; if ({ap_done, ap_ready, z_read} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b exp=000", {ap_done, ap_ready, z_read}); end
    checks++; if (ap_return_sum !== '0 || ap_return_max !== '0) begin errors++; $display("FAIL reset_ret got=%0d/%0d exp=0/0", ap_return_sum, ap_return_max); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick();
    checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL idle_after_reset got=%b exp=1", ap_idle); end
  endtask

  task automatic test_basic();
    logic zr0;
    push_words(1, 2, 3, 4);
    launch(1'b0, zr0);
    run_txn();
    checks++; if (r_nreads != 4 || r_ready != 4 || r_ready_cnt != 1) begin errors++; $display("FAIL basic_reads got=%0d/%0d/%0d exp=4/4/1", r_nreads, r_ready, r_ready_cnt); end
    checks++; if (r_done != 5) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=5", r_done); end
    checks++; if (r_sum !== SW'(10) || r_max !== W'(4)) begin errors++; $display("FAIL basic_result got=%0d/%0d exp=10/4", r_sum, r_max); end
    release_done();
    #1;
    checks++; if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin errors++; $display("FAIL basic_to_idle got=%b%b exp=10", ap_idle, ap_done); end
  endtask

  task automatic test_full_scale();
    logic zr0;
    push_words(2047, 2047, 2047, 2047);
    launch(1'b0, zr0);
    run_txn();
    checks++; if (r_sum !== SW'(8188) || r_max !== W'(2047)) begin errors++; $display("FAIL full_scale got=%0d/%0d exp=8188/2047", r_sum, r_max); end
    release_done();
  endtask

  task automatic test_gaps();
    logic zr0;
    gap_cfg = 3;
    push_words(5, 9, 0, 7);
    launch(1'b0, zr0);
    run_txn();
    checks++; if (r_bad != 0) begin errors++; $display("FAIL gaps_read_when_empty got=%0d exp=0", r_bad); end
    checks++; if (r_ready != 13 || r_done != 14) begin errors++; $display("FAIL gaps_timing got=%0d/%0d exp=13/14", r_ready, r_done); end
    checks++; if (r_sum !== SW'(21) || r_max !== W'(9)) begin errors++; $display("FAIL gaps_result got=%0d/%0d exp=21/9", r_sum, r_max); end
    gap_cfg = 0; gap_left = 0;
    release_done();
  endtask

  task automatic test_ce_pause();
    logic zr0;
    push_random();
    pause_after = 2; pause_len = 2;
    launch(1'b0, zr0);
    run_txn();
    pause_after = -1; pause_len = 0;
    checks++; if (r_bad != 0) begin errors++; $display("FAIL ce_frozen got=%0d exp=0", r_bad); end
    checks++; if (r_ready != 6 || r_done != 7) begin errors++; $display("FAIL ce_timing got=%0d/%0d exp=6/7", r_ready, r_done); end
    checks++; if (r_sum !== SW'(model_sum(exp_q)) || r_max !== W'(model_max(exp_q))) begin
      errors++; $display("FAIL ce_result got=%0d/%0d exp=%0d/%0d", r_sum, r_max, model_sum(exp_q), model_max(exp_q)); end
    release_done();
  endtask

  task automatic test_back_to_back();
    logic zr0;
    logic [SW-1:0] hs;
    logic [W-1:0]  hm;
    int hold_bad = 0;
    push_random();
    launch(1'b0, zr0);
    run_txn();
    hs = SW'(model_sum(exp_q)); hm = W'(model_max(exp_q));
    push_random();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ap_done !== 1'b1 || z_read !== 1'b0 || ap_return_sum !== hs || ap_return_max !== hm) hold_bad++;
    end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL hold_done got=%0d bad cycles exp=0", hold_bad); end
    launch(1'b1, zr0);
    checks++; if (zr0 !== 1'b0) begin errors++; $display("FAIL b2b_read_in_continue got=%b exp=0", zr0); end
    run_txn();
    checks++; if (r_idle_seen != 0 || r_done != 5 || r_nreads != 4) begin
      errors++; $display("FAIL b2b_timing got=idle%0d/done%0d/rd%0d exp=0/5/4", r_idle_seen, r_done, r_nreads); end
    checks++; if (r_sum !== SW'(model_sum(exp_q)) || r_max !== W'(model_max(exp_q))) begin
      errors++; $display("FAIL b2b_result got=%0d/%0d exp=%0d/%0d", r_sum, r_max, model_sum(exp_q), model_max(exp_q)); end
    release_done();
  endtask

  task automatic test_reset_mid_read();
    logic zr0;
    push_words(100, 200, 300, 400);
    launch(1'b0, zr0);
    tick();
    tick();
    #2 ap_rst_n = 1'b0;
    #1;
    checks++; if (ap_idle !== 1'b1 || {ap_done, ap_ready, z_read} !== 3'b000) begin
      errors++; $display("FAIL midreset_ctrl got=%b%b%b%b exp=1000", ap_idle, ap_done, ap_ready, z_read); end
    checks++; if (ap_return_sum !== '0 || ap_return_max !== '0) begin errors++; $display("FAIL midreset_ret got=%0d/%0d exp=0/0", ap_return_sum, ap_return_max); end
    checks++; if (fifo.size() != 2) begin errors++; $display("FAIL midreset_popped got=%0d left exp=2", fifo.size()); end
    fifo.delete();
    rd_q = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    push_words(1, 1, 1, 1);
    launch(1'b0, zr0);
    run_txn();
    checks++; if (r_done != 5 || r_sum !== SW'(4) || r_max !== W'(1)) begin
      errors++; $display("FAIL midreset_next got=done%0d %0d/%0d exp=5 4/1", r_done, r_sum, r_max); end
    release_done();
  endtask

  task automatic test_random();
    logic zr0;
    int exp_done;
    logic b2b = 1'b0;
    for (int t = 0; t < 20; t++) begin
      gap_cfg = $urandom_range(0, 2);
      push_random();
      launch(b2b, zr0);
      run_txn();
      exp_done = N + 1 + gap_cfg * (N - 1);
      checks++; if (r_bad != 0 || r_done != exp_done || r_ready_cnt != 1) begin
        errors++; $display("FAIL rand_timing t=%0d got=bad%0d done%0d rdy%0d exp=0/%0d/1", t, r_bad, r_done, r_ready_cnt, exp_done); end
      checks++; if (r_sum !== SW'(model_sum(exp_q)) || r_max !== W'(model_max(exp_q))) begin
        errors++; $display("FAIL rand_result t=%0d got=%0d/%0d exp=%0d/%0d", t, r_sum, r_max, model_sum(exp_q), model_max(exp_q)); end
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) release_done();
    end
    gap_cfg = 0; gap_left = 0;
    if (b2b) release_done();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_scale();
    test_gaps();
    test_ce_pause();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
